// File: rtl/misc_mem_pkg.sv
// misc_mem_pkg: shared widths and enums for the memory port arbiter
package misc_mem_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {GNT_IF, GNT_LS} grant_t;
endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant, one-hot {ls, if}
module rr_arbiter2
   import misc_mem_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   output logic [1:0] gnt
);
   assign gnt[0] = req[0] & (~req[1] | (last_grant == GNT_LS));
   assign gnt[1] = req[1] & (~req[0] | (last_grant == GNT_IF));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and load/store onto the single-port Memory
module mem_port_arbiter #(
   parameter int ADDR_W       = misc_mem_pkg::ADDR_W,
   parameter int DATA_W       = misc_mem_pkg::DATA_W,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_resp_data,
   input  logic              ls_req_valid,
   input  logic              ls_req_we,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic [DATA_W-1:0] ls_req_wdata,
   output logic              ls_req_ready,
   output logic              ls_resp_valid,
   output logic [DATA_W-1:0] ls_resp_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_w,
   output logic              mem_r,
   input  logic [DATA_W-1:0] mem_q
);
   import misc_mem_pkg::*;
   // cnt holds remaining BUSY edges minus one, so latency 4 still fits in 2 bits
   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);
   state_t     state, state_n;
   grant_t     last_grant, owner;
   logic [1:0] cnt, gnt;
   logic       idle, accept, store;

   rr_arbiter2 u_arb (.req({ls_req_valid, if_req_valid}), .last_grant(last_grant), .gnt(gnt));

   always_comb begin
      idle         = rst_n && (state == IDLE);
      if_req_ready = idle & gnt[0];
      ls_req_ready = idle & gnt[1];
      accept       = if_req_ready | ls_req_ready;
      store        = ls_req_ready & ls_req_we;
      mem_r        = accept & ~store;
      mem_w        = store;
      mem_addr     = if_req_ready ? if_req_addr : (ls_req_ready ? ls_req_addr : '0);
      mem_data     = store ? ls_req_wdata : '0;
      state_n      = (state == IDLE) ? (mem_r ? BUSY : IDLE) : ((cnt == 2'd0) ? IDLE : BUSY);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= 2'd0;
         last_grant    <= GNT_IF;
         owner         <= GNT_IF;
         if_resp_valid <= 1'b0;
         if_resp_data  <= '0;
         ls_resp_valid <= 1'b0;
         ls_resp_data  <= '0;
      end else begin
         if_resp_valid <= 1'b0;
         ls_resp_valid <= store;
         if (accept) last_grant <= ls_req_ready ? GNT_LS : GNT_IF;
         if (store) ls_resp_data <= '0;
         if (mem_r) begin
            cnt   <= CNT_INIT;
            owner <= ls_req_ready ? GNT_LS : GNT_IF;
         end else if (state == BUSY) begin
            if (cnt != 2'd0) cnt <= cnt - 2'd1;
            else if (owner == GNT_IF) begin
               if_resp_valid <= 1'b1;
               if_resp_data  <= mem_q;
            end else begin
               ls_resp_valid <= 1'b1;
               ls_resp_data  <= mem_q;
            end
         end
      end
   end

   a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
      if_req_valid && !if_req_ready |=> if_req_valid && $stable(if_req_addr));
   a_ls_hold: assert property (@(posedge clk) disable iff (!rst_n)
      ls_req_valid && !ls_req_ready |=> ls_req_valid && $stable({ls_req_we, ls_req_addr, ls_req_wdata}));
endmodule
